aes192_keyctl: RTL and testbench
================================

# aes192_keyctl

Sequencer for the 192-bit AES key-schedule engine: it latches a key on a start handshake, drives the engine's control strobes through forward expansion and, for decryption, reverse expansion, and tags each emitted round key with its round index. It sits between the cipher round core, which consumes round keys and may stall, and the key-expansion datapath, which emits one 128-bit round key per advancing cycle. Encrypt yields round keys 0..12 in ascending order; decrypt yields 12..0.

## Interface
- LAST_ROUND, default 12: index of the final round key (AES-192).
- CW, default 4: round-counter width; must satisfy 2^CW > LAST_ROUND.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a key schedule; accepted only in IDLE.
- decrypt  in  1  sampled with accepted start: 0 = forward order, 1 = reverse order.
- key_in  in  192  cipher key, sampled with accepted start.
- hold  in  1  round core stall; freezes sequencing while in FWD/REV.
- key_out  out  192  latched key to engine key input.
- exp_reset  out  1  engine synchronous clear/load, active-high.
- exp_done1  out  1  engine direction: 0 = forward, 1 = reverse.
- exp_done2  out  1  engine freeze, active-high.
- exp_predone  out  1  engine turnaround strobe on last forward step before reversal.
- round  out  CW  index of the round key currently presented by the engine.
- rk_valid  out  1  round key and round index are valid this cycle.
- busy  out  1  schedule in progress: high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, FWD, REV, FIN. Registers: state, cnt[CW-1:0], dir, key_out.
- IDLE: exp_reset=1, exp_done2=0. On start=1: latch key_in→key_out and decrypt→dir, cnt←0, go to LOAD.
- LOAD: one cycle, exp_reset=1, so the engine loads key_out. Next state is FWD.
- FWD: exp_reset=0, exp_done1=0.
  - Encrypt: rk_valid=1, round=cnt. At cnt==LAST_ROUND go to FIN, else cnt+1.
  - Decrypt: rk_valid=0. exp_predone=1 when cnt==LAST_ROUND-1; that same cycle go to REV with cnt←LAST_ROUND, else cnt+1.
- REV: exp_done1=1, rk_valid=1, round=cnt. At cnt==0 go to FIN, else cnt−1.
- FIN: exp_done2=1, done=1 for one cycle, rk_valid=0. Next state is IDLE.
- hold=1 in FWD or REV:
  - Force exp_done2=1, rk_valid=0 and exp_predone=0.
  - Freeze state and cnt.
  - Keep exp_done1 at its state value.
  - hold is ignored in other states.
- start outside IDLE is ignored. key_in and decrypt are don't-care except at acceptance.
- round=cnt in all states. cnt never wraps: the decrement stops at 0 and the increment stops at LAST_ROUND.

## Timing
- Reset (asynchronous assert, release synchronized to the next clk edge):
  - state=IDLE, cnt=0, dir=0, key_out=0.
  - exp_reset=1; all other outputs 0.
- All outputs are combinational from registered state/cnt plus hold only; there is no path from start to outputs.
- Latency from the start-accept edge:
  - LOAD is the next cycle.
  - First rk_valid is 2 cycles after acceptance.
  - Encrypt: 13 valid cycles, then done on the cycle after round 12. Start-to-done is 15 cycles with no hold.
  - Decrypt: 12 FWD cycles without valid, then 13 REV valid cycles (12..0), then done. Start-to-done is 27 cycles.
- Each hold cycle extends the schedule by exactly one cycle.
- Reset mid-schedule returns to IDLE immediately and asynchronously; no done pulse is produced.
- start in the same cycle as FIN is ignored; start in the cycle after FIN (IDLE) is accepted.

## Test plan
- **Encrypt, FIPS-197 key** (8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b), decrypt=0, with the real engine:
  - Round 0 key = 8e73b0f7da0e6452c810f32b809079e5.
  - Round 12 key = e98ba06f448c773c8ecc720401002202.
  - done pulses at cycle 15.
- **Decrypt, same key:** rk_valid first with round=12 and key e98ba06f…01002202; last valid round=0 with key 8e73b0f7…809079e5. exp_predone is high for exactly one cycle, with cnt=11. done pulses at cycle 27.
- **hold stall:** encrypt with hold=1 for 3 cycles at round=5. rk_valid=0 and exp_done2=1 during the stall; round stays at 5 and the round-5 key is unchanged. done pulses at cycle 18.
- **Start while busy:** pulse start at round 7 with a different key. No effect on sequence or key_out; the single done pulse arrives on schedule.
- **Reset mid-decrypt:** assert reset at REV round 6. Outputs go to reset values without waiting for clk; no done pulse. A new start after release produces a full, correct encrypt sequence.
- **Back-to-back:** hold start=1 continuously. Schedules repeat with exactly one IDLE cycle between each done and the next LOAD.

Source files
------------

// File: rtl/aes192_keyctl.sv
// rtl/aes192_keyctl.sv - AES-192 key-schedule sequencer with round tagging and stall support
module aes192_keyctl #(
   parameter int LAST_ROUND = 12,
   parameter int CW         = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           decrypt,
   input  logic [191:0]   key_in,
   input  logic           hold,
   output logic [191:0]   key_out,
   output logic           exp_reset,
   output logic           exp_done1,
   output logic           exp_done2,
   output logic           exp_predone,
   output logic [CW-1:0]  round,
   output logic           rk_valid,
   output logic           busy,
   output logic           done
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      FWD  = 3'd2,
      REV  = 3'd3,
      FIN  = 3'd4
   } state_t;

   localparam logic [CW-1:0] LAST    = CW'(LAST_ROUND);
   localparam logic [CW-1:0] LAST_M1 = CW'(LAST_ROUND - 1);

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic            dir;
   logic            stalled;

   // The round core only stalls the sequencing states; hold elsewhere is meaningless.
   assign stalled = hold && ((state == FWD) || (state == REV));

   // State, round counter, direction and key registers; key/dir captured only on acceptance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         dir     <= 1'b0;
         key_out <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == IDLE && start) begin
            key_out <= key_in;
            dir     <= decrypt;
         end
      end
   end

   // Next-state and counter update; counter saturates at both ends instead of wrapping.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = LOAD;
               cnt_nxt   = '0;
            end
         end
         LOAD: state_nxt = FWD;
         FWD: begin
            if (!stalled) begin
               if (!dir) begin
                  if (cnt == LAST) state_nxt = FIN;
                  else             cnt_nxt   = cnt + CW'(1);
               end else begin
                  if (cnt == LAST_M1) begin
                     state_nxt = REV;
                     cnt_nxt   = LAST;
                  end else if (cnt != LAST) begin
                     cnt_nxt = cnt + CW'(1);
                  end
               end
            end
         end
         REV: begin
            if (!stalled) begin
               if (cnt == '0) state_nxt = FIN;
               else           cnt_nxt   = cnt - CW'(1);
            end
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Engine strobes and round tagging, decoded from registered state plus hold only.
   always_comb begin
      exp_reset   = 1'b0;
      exp_done1   = 1'b0;
      exp_done2   = 1'b0;
      exp_predone = 1'b0;
      rk_valid    = 1'b0;
      done        = 1'b0;
      busy        = (state != IDLE);
      round       = cnt;
      case (state)
         IDLE: exp_reset = 1'b1;
         LOAD: exp_reset = 1'b1;
         FWD: begin
            if (stalled) begin
               exp_done2 = 1'b1;
            end else begin
               rk_valid    = !dir;
               exp_predone = dir && (cnt == LAST_M1);
            end
         end
         REV: begin
            exp_done1 = 1'b1;
            if (stalled) exp_done2 = 1'b1;
            else         rk_valid  = 1'b1;
         end
         FIN: begin
            exp_done2 = 1'b1;
            done      = 1'b1;
         end
         default: exp_reset = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_aes192_keyctl.sv
// tb/tb_aes192_keyctl.sv - self-checking bench for aes192_keyctl against a schedule-list model
module tb_aes192_keyctl;

   localparam logic [191:0] FIPS_KEY = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;

   localparam int K_LOAD = 0;
   localparam int K_F    = 1;
   localparam int K_R    = 2;
   localparam int K_FIN  = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          decrypt = 1'b0;
   logic [191:0]  key_in = '0;
   logic          hold = 1'b0;
   logic [191:0]  key_out;
   logic          exp_reset, exp_done1, exp_done2, exp_predone;
   logic [3:0]    round;
   logic          rk_valid, busy, done;

   aes192_keyctl dut (
      .clk(clk), .reset(reset), .start(start), .decrypt(decrypt), .key_in(key_in),
      .hold(hold), .key_out(key_out), .exp_reset(exp_reset), .exp_done1(exp_done1),
      .exp_done2(exp_done2), .exp_predone(exp_predone), .round(round),
      .rk_valid(rk_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;
      int rnd;
      bit valid;
      bit pre;
   } step_t;

   typedef struct {
      bit er, d1, d2, pre, val, bsy, dn;
      int rnd;
   } exp_t;

   typedef struct {
      bit           dc;
      logic [191:0] key;
      int           hold_rnd;
      int           hold_len;
      int           busy_rnd;
      int           lat;
      int           first_rnd;
      int           last_rnd;
   } vec_t;

   int checks = 0;
   int errors = 0;

   step_t        sched[$];
   int           pos;
   bit           m_idle = 1'b1;
   int           m_last_rnd = 0;
   logic [191:0] m_key = '0;

   int cyc = 0;
   int acc_cyc = 0;
   int n_done, n_pre, last_lat, first_val, last_val;
   int done_cycles[$];

   task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic void model_reset();
      m_idle = 1'b1;
      m_key = '0;
      m_last_rnd = 0;
      sched.delete();
      pos = 0;
   endfunction

   function automatic void build(input bit dc);
      step_t s;
      sched.delete();
      s = '{kind: K_LOAD, rnd: 0, valid: 0, pre: 0};
      sched.push_back(s);
      if (!dc) begin
         for (int r = 0; r <= 12; r++) begin
            s = '{kind: K_F, rnd: r, valid: 1, pre: 0};
            sched.push_back(s);
         end
         s = '{kind: K_FIN, rnd: 12, valid: 0, pre: 0};
         sched.push_back(s);
      end else begin
         for (int r = 0; r <= 11; r++) begin
            s = '{kind: K_F, rnd: r, valid: 0, pre: (r == 11)};
            sched.push_back(s);
         end
         for (int r = 12; r >= 0; r--) begin
            s = '{kind: K_R, rnd: r, valid: 1, pre: 0};
            sched.push_back(s);
         end
         s = '{kind: K_FIN, rnd: 0, valid: 0, pre: 0};
         sched.push_back(s);
      end
      pos = 0;
   endfunction

   function automatic exp_t model_out(input bit hd);
      exp_t  e;
      step_t s;
      e = '{er: 0, d1: 0, d2: 0, pre: 0, val: 0, bsy: 0, dn: 0, rnd: 0};
      if (m_idle) begin
         e.er  = 1;
         e.rnd = m_last_rnd;
      end else begin
         s = sched[pos];
         e.bsy = 1;
         e.rnd = s.rnd;
         if ((s.kind == K_F || s.kind == K_R) && hd) begin
            e.d1 = (s.kind == K_R);
            e.d2 = 1;
         end else begin
            case (s.kind)
               K_LOAD: e.er = 1;
               K_F: begin
                  e.val = s.valid;
                  e.pre = s.pre;
               end
               K_R: begin
                  e.d1  = 1;
                  e.val = 1;
               end
               default: begin
                  e.d2 = 1;
                  e.dn = 1;
               end
            endcase
         end
      end
      return e;
   endfunction

   function automatic void model_advance(input bit st, input bit hd, input bit dc,
                                         input logic [191:0] ky);
      step_t s;
      if (m_idle) begin
         if (st) begin
            build(dc);
            m_key   = ky;
            m_idle  = 1'b0;
            acc_cyc = cyc;
         end
      end else begin
         s = sched[pos];
         if (!((s.kind == K_F || s.kind == K_R) && hd)) begin
            m_last_rnd = s.rnd;
            pos++;
            if (pos == sched.size()) m_idle = 1'b1;
         end
      end
   endfunction

   task automatic cycle(input bit st, input bit hd, input bit dc, input logic [191:0] ky);
      exp_t e;
      @(negedge clk);
      start = st;
      hold = hd;
      decrypt = dc;
      key_in = ky;
      #1;
      e = model_out(hd);
      chk("exp_reset", exp_reset, e.er);
      chk("exp_done1", exp_done1, e.d1);
      chk("exp_done2", exp_done2, e.d2);
      chk("exp_predone", exp_predone, e.pre);
      chk("rk_valid", rk_valid, e.val);
      chk("busy", busy, e.bsy);
      chk("done", done, e.dn);
      chk("round", round, e.rnd);
      chk("key_out", key_out, m_key);
      if (done === 1'b1) begin
         n_done++;
         last_lat = cyc - acc_cyc;
         done_cycles.push_back(cyc);
      end
      if (exp_predone === 1'b1) n_pre++;
      if (rk_valid === 1'b1) begin
         if (first_val < 0) first_val = int'(round);
         last_val = int'(round);
      end
      model_advance(st, hd, dc, ky);
      cyc++;
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int    stalls;
      bit    hd, st;
      step_t s;
      n_done = 0;
      n_pre = 0;
      first_val = -1;
      last_val = -1;
      last_lat = -1;
      stalls = 0;
      cycle(1'b1, 1'b0, v.dc, v.key);
      for (int i = 0; i < 80 && !m_idle; i++) begin
         s = sched[pos];
         hd = 1'b0;
         st = 1'b0;
         if (v.hold_len > 0 && stalls < v.hold_len && s.valid && s.rnd == v.hold_rnd) begin
            hd = 1'b1;
            stalls++;
         end
         if (v.busy_rnd >= 0 && s.valid && s.rnd == v.busy_rnd && !hd) st = 1'b1;
         cycle(st, hd, ~v.dc, st ? ~v.key : 192'd0);
      end
      cycle(1'b0, 1'b0, 1'b0, 192'd0);
      chk({nm, "_done_count"}, n_done, 1);
      chk({nm, "_latency"}, last_lat, v.lat);
      chk({nm, "_predone_count"}, n_pre, v.dc ? 1 : 0);
      chk({nm, "_first_round"}, first_val, v.first_rnd);
      chk({nm, "_last_round"}, last_val, v.last_rnd);
      chk({nm, "_key"}, key_out, v.key);
   endtask

   vec_t vecs[7];

   initial begin
      step_t s;
      bit    hit;

      vecs[0] = '{dc: 0, key: FIPS_KEY, hold_rnd: -1, hold_len: 0, busy_rnd: -1, lat: 15, first_rnd: 0, last_rnd: 12};
      vecs[1] = '{dc: 1, key: FIPS_KEY, hold_rnd: -1, hold_len: 0, busy_rnd: -1, lat: 27, first_rnd: 12, last_rnd: 0};
      vecs[2] = '{dc: 0, key: FIPS_KEY, hold_rnd: 5, hold_len: 3, busy_rnd: -1, lat: 18, first_rnd: 0, last_rnd: 12};
      vecs[3] = '{dc: 0, key: 192'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978, hold_rnd: -1, hold_len: 0, busy_rnd: 7, lat: 15, first_rnd: 0, last_rnd: 12};
      vecs[4] = '{dc: 1, key: 192'h55aa55aa55aa55aa_aa55aa55aa55aa55_123456789abcdef0, hold_rnd: 4, hold_len: 2, busy_rnd: 9, lat: 29, first_rnd: 12, last_rnd: 0};
      vecs[5] = '{dc: 0, key: 192'hffffffffffffffff_0000000000000000_ffffffffffffffff, hold_rnd: 0, hold_len: 1, busy_rnd: -1, lat: 16, first_rnd: 0, last_rnd: 12};
      vecs[6] = '{dc: 1, key: 192'hdeadbeefdeadbeef_cafef00dcafef00d_0badc0de0badc0de, hold_rnd: 0, hold_len: 4, busy_rnd: -1, lat: 31, first_rnd: 12, last_rnd: 0};

      // reset state
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_exp_reset", exp_reset, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_rk_valid", rk_valid, 1'b0);
      chk("rst_round", round, 4'd0);
      chk("rst_key_out", key_out, 192'd0);
      @(negedge clk);
      reset = 1'b1;

      // table-driven schedules
      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // reset in the middle of the reverse pass
      n_done = 0;
      cycle(1'b1, 1'b0, 1'b1, FIPS_KEY);
      hit = 1'b0;
      for (int i = 0; i < 60 && !hit; i++) begin
         s = sched[pos];
         if (s.kind == K_R && s.rnd == 6) hit = 1'b1;
         else cycle(1'b0, 1'b0, 1'b0, 192'd0);
      end
      chk("midrst_reached_rev6", hit, 1'b1);
      @(negedge clk);
      start = 1'b0;
      hold = 1'b0;
      #1;
      chk("midrst_pre_round", round, 4'd6);
      chk("midrst_pre_done1", exp_done1, 1'b1);
      #1;
      reset = 1'b0;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_exp_reset", exp_reset, 1'b1);
      chk("midrst_exp_done1", exp_done1, 1'b0);
      chk("midrst_rk_valid", rk_valid, 1'b0);
      chk("midrst_round", round, 4'd0);
      chk("midrst_key_out", key_out, 192'd0);
      chk("midrst_done", done, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      chk("midrst_hold_done", done, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      chk("midrst_no_done_pulse", n_done, 0);
      run_vec(vecs[0], "after_reset");

      // back-to-back with start held high
      done_cycles.delete();
      for (int i = 0; i < 70; i++) cycle(1'b1, 1'b0, 1'b0, FIPS_KEY);
      chk("b2b_done_count", done_cycles.size(), 4);
      for (int i = 1; i < done_cycles.size(); i++)
         chk("b2b_done_spacing", done_cycles[i] - done_cycles[i-1], 16);

      // randomized traffic against the schedule model
      for (int i = 0; i < 2500; i++) begin
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
               {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
